// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared CPU definitions for the RV32M multiply/divide unit: funct3
//   encodings, FSM state encoding, iteration-count width, and the
//   operand-signedness helpers used by the decoder and the control unit.
package muldiv_unit_pkg;

    localparam int unsigned ITER_W = 5;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // MUL is treated as signed/signed; the low product bits are identical
    // whichever signedness is used.
    function automatic logic a_is_signed(input funct3_e f);
        return f inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic b_is_signed(input funct3_e f);
        return f inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit: one radix-2 step per clock
//   (shift-add multiply, restoring divide) on operand magnitudes, with
//   sign fix-up applied as the final result is loaded.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-low reset
//   start   - operation request, sampled only in IDLE
//   funct3  - RV32M operation select
//   op_a    - rs1 value
//   op_b    - rs2 value
//   abort   - cancel in-flight operation (BUSY/DONE)
//   busy    - operation in progress
//   done    - one-cycle pulse, result valid
//   result  - registered result, held until the next accepted start
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state;
    funct3_e             op;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opnd;
    logic                neg;
    logic [ITER_W-1:0]   cnt;
    logic                early;

    // Operand decode for the capture edge
    funct3_e         f_in;
    logic            a_neg, b_neg, neg_in, div0, ovf;
    logic [XLEN-1:0] a_mag, b_mag, special;

    always_comb begin
        f_in   = funct3_e'(funct3);
        a_neg  = a_is_signed(f_in) && op_a[XLEN-1];
        b_neg  = b_is_signed(f_in) && op_b[XLEN-1];
        a_mag  = a_neg ? -op_a : op_a;
        b_mag  = b_neg ? -op_b : op_b;
        // Remainder follows the dividend sign; everything else the XOR.
        neg_in = (f_in == F3_REM) ? a_neg : (a_neg ^ b_neg);
        div0   = funct3[2] && (op_b == '0);
        ovf    = (f_in == F3_DIV || f_in == F3_REM) && (op_a == INT_MIN) && (op_b == '1);
        if (div0) special = funct3[1] ? op_a : '1;
        else      special = funct3[1] ? '0 : INT_MIN;
    end

    // One iteration step. acc holds {hi, lo}: for multiply lo is the
    // multiplier being shifted out; for divide lo is the dividend being
    // shifted in and collects quotient bits, hi holds the partial remainder.
    logic [XLEN:0]     rem_sh, trial, sum;
    logic [XLEN-1:0]   addend;
    logic [2*XLEN-1:0] acc_nxt, prod;
    logic [XLEN-1:0]   quo, rem, final_val;

    always_comb begin
        rem_sh = acc[2*XLEN-1:XLEN-1];
        trial  = rem_sh - {1'b0, opnd};
        addend = acc[0] ? opnd : '0;
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
        if (op[2]) begin
            if (!trial[XLEN]) acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else              acc_nxt = {acc[2*XLEN-2:0], 1'b0};
        end else begin
            acc_nxt = {sum, acc[XLEN-1:1]};
        end

        prod = neg ? -acc_nxt : acc_nxt;
        quo  = neg ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem  = neg ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        case (op)
            F3_MUL:                      final_val = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_val = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             final_val = quo;
            default:                     final_val = rem;
        endcase
    end

    // Divide-by-zero and signed overflow are resolved at capture: the fixed
    // answer is parked in acc and 'early' spends one IDLE cycle (busy low)
    // before DONE, so done lands one edge after the accepting edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            op     <= F3_MUL;
            acc    <= '0;
            opnd   <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            early  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (early) begin
                        early  <= 1'b0;
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        result <= acc[XLEN-1:0];
                    end else if (start && !abort) begin
                        op   <= f_in;
                        neg  <= neg_in;
                        cnt  <= '0;
                        opnd <= b_mag;
                        if (div0 || ovf) begin
                            early <= 1'b1;
                            acc   <= {{XLEN{1'b0}}, special};
                        end else begin
                            acc   <= {{XLEN{1'b0}}, a_mag};
                            state <= ST_BUSY;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + ITER_W'(1);
                        if (cnt == '1) begin
                            state  <= ST_DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            result <= final_val;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Directed-vector bench for muldiv_unit with hand-computed results,
//   latency, busy/done timing, start-ignore, abort and async reset checks.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one operation and watch 70 cycles. Sample k is taken between
    // E(k-1) and Ek, so done first seen at sample k means latency k-1.
    // poke>0 re-pulses start (with different operands) so it is sampled at E<poke>.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int exp_lat, input int poke);
        int  lat = -1;
        int  ndone = 0;
        bit  busy_bad = 0;
        bit  excl_bad = 0;
        bit  busy_exp;
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(posedge clk);
        #1 start = 1'b0; op_a = ~a; op_b = ~b;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            busy_exp = (exp_lat == 32) && (k <= 32);
            if (busy !== busy_exp) busy_bad = 1;
            if (busy && done) excl_bad = 1;
            if (done === 1'b1) begin
                if (lat < 0) lat = k - 1;
                ndone++;
            end
            if (k == poke) begin
                start = 1'b1; funct3 = 3'b011; op_a = '1; op_b = '1;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, exp);
        check({tag, "_ndone"}, 32'(ndone), 32'd1);
        check({tag, "_busy"}, {30'd0, excl_bad, busy_bad}, 32'd0);
    endtask

    initial begin
        int nd;
        // Reset state, no clock edge needed
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        do_op("mul",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32, 0);
        do_op("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, 0);
        do_op("mulh",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32, 0);
        do_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 0);
        do_op("mul_wrap", 3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 32, 0);
        do_op("mulhu_1",  3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 32, 0);
        do_op("div_neg",  3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32, 0);
        do_op("rem_neg",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32, 0);
        do_op("div_negb", 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32, 0);
        do_op("rem_negb", 3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32, 0);
        do_op("divu",     3'b101, 32'd100,      32'd7,        32'd14,       32, 0);
        do_op("remu",     3'b111, 32'd100,      32'd7,        32'd2,        32, 0);
        do_op("divu_z",   3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1,  0);
        do_op("remu_z",   3'b111, 32'd100,      32'd0,        32'd100,      1,  0);
        do_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
        do_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  0);
        do_op("mul_poke", 3'b000, 32'd3,        32'd5,        32'd15,       32, 5);

        // Abort sampled at E10: IDLE after E10, no done, result keeps 15
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        nd = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
            if (k == 10) check("abort_busy_pre", {31'd0, busy}, 32'd1);
            if (k == 11) check("abort_busy_post", {31'd0, busy}, 32'd0);
            abort = (k == 10);
        end
        check("abort_ndone", 32'(nd), 32'd0);
        check("abort_result", result, 32'd15);

        // Reset mid-BUSY between edges clears outputs immediately
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        do_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 32, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: op_a  input  32  rs1 value from the register file.
REQ-007 SHALL have port: op_b  input  32  rs2 value from the register file.
REQ-008 SHALL have port: abort  input  1  cancel the in-flight operation (pipeline flush).
REQ-009 SHALL have port: busy  output  1  high in BUSY; the CPU holds the PC and the register-file write enable while busy is high.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; result is valid and may be written to rd.
REQ-011 SHALL have port: result  output  32  registered result; held until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 SHALL, in IDLE with start=1 at an edge (E0), capture funct3, op_a and op_b, clear the iteration count, and enter BUSY.
REQ-014 SHALL perform one radix-2 iteration per edge in BUSY: shift-add for multiply, restoring shift-subtract for divide, on 32-bit operand magnitudes.
REQ-015 SHALL leave BUSY after the 32nd iteration at E32, enter DONE, and load result; done=1 and busy=0 for the cycle between E32 and E33.
REQ-016 SHALL go from DONE to IDLE unconditionally on the next edge; start is not accepted in DONE.
REQ-017 SHALL ignore start in BUSY and DONE; operand changes after E0 SHALL NOT affect result.
REQ-018 SHALL select the result as follows: MUL -> low 32 bits of the 64-bit product; MULH/MULHSU/MULHU -> high 32 bits, with operands signed/signed, signed/unsigned and unsigned/unsigned respectively.
REQ-019 SHALL, for DIV and REM, use magnitudes internally; the quotient is negative iff the operand signs differ, and the remainder takes the sign of the dividend (truncating division).
REQ-020 SHALL, on divide by zero, return quotient 0xFFFFFFFF for DIV and DIVU, and remainder op_a for REM and REMU.
REQ-021 SHALL, on signed overflow (DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF), return DIV=0x80000000 and REM=0.
REQ-022 SHALL detect the cases in REQ-020 and REQ-021 at E0 and go IDLE->DONE directly, so that done is high between E1 and E2 and busy never asserts.
REQ-023 SHALL, on abort=1 at an edge in BUSY or DONE, return to IDLE with done=0 and result unchanged; abort in IDLE has no effect and takes priority over start.
REQ-024 SHALL keep done and busy mutually exclusive at all times.

Reset
REQ-025 SHALL, while reset=0 and independent of clk, force state=IDLE, busy=0, done=0, result=0x00000000, iteration count=0, and clear all operand/accumulator registers.
REQ-026 SHALL treat reset asserted mid-operation as an abort without done; the first start after deassertion SHALL behave as from power-up.

Structure
REQ-027 SHALL define the funct3 encodings, the FSM state encoding and the iteration-count width (5 bits) in the shared CPU package used by the decoder and the control unit.
REQ-028 SHALL be a single module with no sub-module; the iteration datapath is a 64-bit accumulator plus a 32-bit operand register.

Verification
REQ-029 SHALL cover: MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 32 edges after E0 (visible E32-E33), busy high E0-E32.
REQ-030 SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-032 SHALL cover: DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; for all four, done at E1 and busy never high.
REQ-033 SHALL cover: start pulsed at E5 during BUSY -> ignored, with exactly one done; abort at iteration 10 -> IDLE next edge, no done, result keeps the previous value.
REQ-034 SHALL cover: reset driven low mid-BUSY between edges -> busy=0, done=0, result=0 immediately without a clock edge; the next MUL 3x4 after release -> 12.
